hs_ram_arbiter: RTL and testbench

//  Shares the game work RAM port (11-bit addr, 8-bit data) between the game CPU and the

---
 rtl/hs_ram_arbiter_if.sv | 22 ++
 rtl/hs_ram_arbiter.sv | 127 ++++++++++++
 tb/tb_hs_ram_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hs_ram_arbiter_if.sv
// hs_ram_arbiter_if: hiscore-side request/grant and RAM data handshake
interface hs_ram_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              hs_intent;
  logic [ADDR_W-1:0] hs_addr;
  logic [DATA_W-1:0] hs_wdata;
  logic              hs_we;
  logic              hs_grant;
  logic [DATA_W-1:0] hs_rdata;
  logic              hs_rvalid;
  logic              hs_abort;
  modport master (
    output hs_intent, hs_addr, hs_wdata, hs_we,
    input  hs_grant, hs_rdata, hs_rvalid, hs_abort
  );
  modport slave (
    input  hs_intent, hs_addr, hs_wdata, hs_we,
    output hs_grant, hs_rdata, hs_rvalid, hs_abort
  );
endinterface

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: hands the work RAM port from the CPU to the hiscore engine once the CPU is paused and idle
module hs_ram_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int SETTLE  = 4,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 4096
)(
  input  logic              clk_sys,
  input  logic              reset_n,
  hs_ram_arbiter_if.slave   hs,
  output logic              pause_req,
  input  logic              pause_ack,
  input  logic              cpu_busy,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_clash,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(SETTLE) + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_PAUSE_REQ, ST_SETTLE, ST_GRANT, ST_RELEASE} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       to_q, to_d;
  logic [SW-1:0]       st_q, st_d;
  logic                abort_q, abort_d;
  logic                sel_q, sel_d;
  logic                pause_q, pause_d;
  logic                clash_q, clash_d;
  logic [RD_LAT-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid;

  assign rvalid = rd_q[RD_LAT-1];

  // next-state: request pause, wait for ack with an idle bus, settle, then own the port
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    st_d    = st_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs.hs_intent) begin
          state_d = ST_PAUSE_REQ;
          to_d    = '0;
        end
      end
      ST_PAUSE_REQ: begin
        to_d = to_q + 1'b1;
        if (!hs.hs_intent) state_d = ST_IDLE;
        else if (pause_ack && !cpu_busy) begin
          state_d = ST_SETTLE;
          st_d    = SW'(SETTLE - 1);
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_RELEASE;
          abort_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        st_d = st_q - 1'b1;
        if (!hs.hs_intent) state_d = ST_RELEASE;
        else if (!pause_ack) begin
          state_d = ST_PAUSE_REQ;
          to_d    = '0;
        end else if (st_q == '0) state_d = ST_GRANT;
      end
      ST_GRANT:   state_d = hs.hs_intent ? ST_GRANT : ST_RELEASE;
      ST_RELEASE: state_d = hs.hs_intent ? ST_RELEASE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // registered flags; the read pipe is flushed whenever the next cycle is not granted
  always_comb begin
    sel_d   = state_d == ST_GRANT;
    pause_d = state_d inside {ST_PAUSE_REQ, ST_SETTLE, ST_GRANT};
    clash_d = sel_q & cpu_we;
    rd_d    = sel_d ? RD_LAT'({rd_q, sel_q & ~hs.hs_we}) : '0;
    rdata_d = rvalid ? ram_rdata : rdata_q;
  end

  // RAM mux follows the registered select so it never glitches on state decode
  always_comb begin
    ram_we    = sel_q ? hs.hs_we    : cpu_we;
    ram_addr  = sel_q ? hs.hs_addr  : cpu_addr;
    ram_wdata = sel_q ? hs.hs_wdata : cpu_wdata;
  end

  assign hs.hs_grant  = sel_q;
  assign hs.hs_abort  = abort_q;
  assign hs.hs_rvalid = rvalid;
  assign hs.hs_rdata  = rvalid ? ram_rdata : rdata_q;
  assign pause_req    = pause_q;
  assign cpu_clash    = clash_q;

  // state and flag registers; async reset returns the mux to the CPU immediately
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      to_q    <= '0;
      st_q    <= '0;
      abort_q <= 1'b0;
      sel_q   <= 1'b0;
      pause_q <= 1'b0;
      clash_q <= 1'b0;
      rd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      st_q    <= st_d;
      abort_q <= abort_d;
      sel_q   <= sel_d;
      pause_q <= pause_d;
      clash_q <= clash_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb_hs_ram_arbiter: directed scenarios plus random traffic checked against a behavioural arbiter/RAM model
module tb_hs_ram_arbiter;
  localparam int AW = 11, DW = 8, ST = 4, RL = 1, TO = 16;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  hs_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) hs();
  logic          pause_req, pause_ack, cpu_busy, cpu_we, cpu_clash, ram_we;
  logic [AW-1:0] cpu_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, ram_wdata, ram_rdata;

  hs_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SETTLE(ST), .RD_LAT(RL), .TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .hs(hs),
    .pause_req(pause_req), .pause_ack(pause_ack), .cpu_busy(cpu_busy),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_clash(cpu_clash),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // synchronous RAM with RL cycles of read latency; contents scrambled while in reset
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rp [RL] = '{default: '0};
  always @(posedge clk_sys) begin
    for (int i = RL - 1; i > 0; i--) rp[i] <= rp[i-1];
    rp[0] <= mem[ram_addr];
    if (!reset_n) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'($urandom);
    end else if (ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = rp[RL-1];

  // behavioural model: ph 0=idle 1=asking for pause 2=settling 3=owning the port 4=letting go
  typedef struct {int due; logic [DW-1:0] val;} rd_t;
  rd_t rq[$];
  int ph = 0, nph, waited = 0, settled = 0, cyc = 0;
  logic m_abort = 1'b0, m_clash = 1'b0, owned, exp_rv;

  always @(negedge clk_sys) begin
    cyc++;
    if (!reset_n) begin
      ph = 0; waited = 0; settled = 0; m_abort = 1'b0; m_clash = 1'b0;
      rq.delete();
    end else begin
      owned  = (ph == 3);
      exp_rv = owned && rq.size() > 0 && rq[0].due == cyc;
      chk("m_grant", hs.hs_grant, owned);
      chk("m_pause_req", pause_req, ph >= 1 && ph <= 3);
      chk("m_abort", hs.hs_abort, m_abort);
      chk("m_clash", cpu_clash, m_clash);
      chk("m_rvalid", hs.hs_rvalid, exp_rv);
      if (exp_rv) begin
        chk("m_rdata", hs.hs_rdata, rq[0].val);
        void'(rq.pop_front());
      end
      chk("m_ram_we", ram_we, owned ? hs.hs_we : cpu_we);
      chk("m_ram_addr", ram_addr, owned ? hs.hs_addr : cpu_addr);
      chk("m_ram_wdata", ram_wdata, owned ? hs.hs_wdata : cpu_wdata);
      m_clash = owned && cpu_we;
      m_abort = 1'b0;
      if (owned && !hs.hs_we) rq.push_back('{cyc + RL, mem[hs.hs_addr]});
      nph = ph;
      case (ph)
        0: if (hs.hs_intent) begin nph = 1; waited = 0; end
        1: begin
          if (!hs.hs_intent) nph = 0;
          else if (pause_ack && !cpu_busy) begin nph = 2; settled = 0; end
          else if (waited == TO - 1) begin nph = 4; m_abort = 1'b1; end
          else waited++;
        end
        2: begin
          if (!hs.hs_intent) nph = 4;
          else if (!pause_ack) begin nph = 1; waited = 0; end
          else if (settled == ST - 1) nph = 3;
          else settled++;
        end
        3: if (!hs.hs_intent) nph = 4;
        default: if (!hs.hs_intent) nph = 0;
      endcase
      ph = nph;
      if (ph != 3) rq.delete();
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    hs.hs_intent = 0; hs.hs_addr = '0; hs.hs_wdata = '0; hs.hs_we = 0;
    pause_ack = 0; cpu_busy = 0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_grant", hs.hs_grant, 0);
    chk("rst_pause_req", pause_req, 0);
    chk("rst_rvalid", hs.hs_rvalid, 0);
    chk("rst_abort", hs.hs_abort, 0);
    chk("rst_clash", cpu_clash, 0);
    chk("rst_rdata", hs.hs_rdata, 0);
    chk("rst_ram_we", ram_we, 0);
    reset_n = 1;
    // grant arrives ST cycles after entering settle
    hs.hs_intent = 1;
    tick(); chk("t1_req", pause_req, 1);
    tick(); tick();
    pause_ack = 1;
    repeat (ST) begin tick(); chk("t1_wait", hs.hs_grant, 0); chk("t1_req_hold", pause_req, 1); end
    tick(); chk("t1_grant", hs.hs_grant, 1); chk("t1_req_grant", pause_req, 1);
    // write 0x5A to 0x3C0, read it back
    hs.hs_we = 1; hs.hs_addr = 11'h3C0; hs.hs_wdata = 8'h5A; #1;
    chk("t2_we", ram_we, 1); chk("t2_addr", ram_addr, 11'h3C0); chk("t2_wdata", ram_wdata, 8'h5A);
    tick(); hs.hs_we = 0; #1; chk("t2_rd_we", ram_we, 0);
    tick(); hs.hs_we = 1; hs.hs_addr = 11'h3C1; hs.hs_wdata = 8'h11;
    chk("t2_rvalid", hs.hs_rvalid, 1); chk("t2_rdata", hs.hs_rdata, 8'h5A);
    tick(); chk("t2_rvalid_off", hs.hs_rvalid, 0);
    // drop intent while granted with a read in flight
    hs.hs_intent = 0; hs.hs_we = 0; cpu_addr = 11'h123;
    tick(); chk("t5_grant_off", hs.hs_grant, 0); chk("t5_mux", ram_addr, 11'h123); chk("t5_rv0", hs.hs_rvalid, 0);
    tick(); chk("t5_rv1", hs.hs_rvalid, 0); chk("t5_req_off", pause_req, 0);
    // ack never comes: abort after TO cycles of pause_req
    pause_ack = 0; hs.hs_intent = 1;
    tick(); chk("t3_req", pause_req, 1);
    repeat (TO - 1) begin tick(); chk("t3_req_hold", pause_req, 1); chk("t3_no_abort", hs.hs_abort, 0); end
    tick(); chk("t3_abort", hs.hs_abort, 1); chk("t3_req_drop", pause_req, 0);
    pause_ack = 1;
    repeat (5) begin tick(); chk("t3_no_grant", hs.hs_grant, 0); chk("t3_no_req", pause_req, 0); end
    hs.hs_intent = 0;
    tick(); tick();
    // busy CPU holds off settle; CPU writes during grant are dropped
    cpu_busy = 1; hs.hs_intent = 1;
    tick();
    repeat (10) begin tick(); chk("t4_busy_no_grant", hs.hs_grant, 0); end
    cpu_busy = 0;
    repeat (ST) begin tick(); chk("t4_settle", hs.hs_grant, 0); end
    tick(); chk("t4_grant", hs.hs_grant, 1);
    cpu_we = 1; cpu_wdata = 8'h77; hs.hs_addr = 11'h3C5; #1;
    chk("t4_cpu_blocked", ram_we, 0);
    tick(); chk("t4_clash", cpu_clash, 1);
    hs.hs_we = 1; hs.hs_wdata = 8'h33; #1;
    chk("t4_hs_we", ram_we, 1); chk("t4_hs_wdata", ram_wdata, 8'h33); chk("t4_hs_addr", ram_addr, 11'h3C5);
    tick(); chk("t4_clash2", cpu_clash, 1);
    cpu_we = 0; hs.hs_we = 0;
    tick(); chk("t4_clash_off", cpu_clash, 0);
    hs.hs_intent = 0;
    tick(); tick();
    // intent drops during settle
    hs.hs_intent = 1;
    tick(); tick(); hs.hs_intent = 0;
    tick(); chk("t5s_req_off", pause_req, 0); chk("t5s_grant", hs.hs_grant, 0);
    tick(); chk("t5s_idle", pause_req, 0);
    // async reset mid-grant with a hiscore write pending
    hs.hs_intent = 1;
    tick();
    repeat (ST + 1) tick();
    chk("t6_grant", hs.hs_grant, 1);
    hs.hs_we = 1; hs.hs_addr = 11'h010; hs.hs_wdata = 8'hEE; #1;
    chk("t6_we_before", ram_we, 1);
    #2 reset_n = 0;
    #1;
    chk("t6_we_async", ram_we, 0); chk("t6_grant_async", hs.hs_grant, 0); chk("t6_req_async", pause_req, 0);
    hs.hs_intent = 0; hs.hs_we = 0;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1;
    tick();
    chk("t6_grant_after", hs.hs_grant, 0); chk("t6_req_after", pause_req, 0);
    chk("t6_rvalid_after", hs.hs_rvalid, 0); chk("t6_abort_after", hs.hs_abort, 0);
    chk("t6_clash_after", cpu_clash, 0); chk("t6_we_after", ram_we, 0);
    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 6) hs.hs_intent = ~hs.hs_intent;
      if ($urandom_range(0, 99) < 12) pause_ack = ~pause_ack;
      cpu_busy     = $urandom_range(0, 3) == 0;
      cpu_we       = $urandom_range(0, 3) == 0;
      hs.hs_we     = $urandom_range(0, 1) == 0;
      hs.hs_addr   = AW'(11'h3C0 + $urandom_range(0, 7));
      cpu_addr     = AW'(11'h3C0 + $urandom_range(0, 7));
      hs.hs_wdata  = DW'($urandom);
      cpu_wdata    = DW'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
